// File: rtl/mcp_launch_arb_pkg.sv
// Shared types and default constants for the MCP launch-side arbiter.
package mcp_launch_arb_pkg;

   // Default number of requesters, payload width and busy-handshake timeout.
   localparam int unsigned DefN      = 4;
   localparam int unsigned DefW      = 32;
   localparam int unsigned DefBusyTo = 8;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWaitBusy = 2'd2,
      StWaitDone = 2'd3
   } state_e;

   // Width of an index/counter able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mcp_launch_arb_rr.sv
// Combinational round-robin selector: the first active request at or after
// (i_ptr + 1) mod N wins. i_ptr is the index of the previous winner.
module mcp_launch_arb_rr
   import mcp_launch_arb_pkg::*;
#(
   parameter int unsigned N    = DefN,
   parameter int unsigned IdxW = idx_width(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [IdxW-1:0] i_ptr,
   output logic [N-1:0]    o_gnt_oh,
   output logic [IdxW-1:0] o_gnt_idx,
   output logic            o_gnt_vld
);

   logic [IdxW-1:0] w_slot;

   // Walk the N slots in rotating priority order and keep the first hit.
   always_comb begin
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      w_slot    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_slot = IdxW'((32'(i_ptr) + k) % N);
         if (!o_gnt_vld && i_req[w_slot]) begin
            o_gnt_vld        = 1'b1;
            o_gnt_idx        = w_slot;
            o_gnt_oh[w_slot] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mcp_launch_arb.sv
// Launch-side arbiter for a multi-cycle-path (MCP) synchroniser: picks one of
// N requesters round-robin, hands its payload to the MCP with a single pass
// pulse and then tracks the MCP busy handshake (with a timeout) before the
// next grant. All outputs are registered.
module mcp_launch_arb
   import mcp_launch_arb_pkg::*;
#(
   parameter int unsigned N       = DefN,
   parameter int unsigned W       = DefW,
   parameter int unsigned BUSY_TO = DefBusyTo
) (
   input  logic                  l_clk,
   input  logic                  l_rst,
   input  logic [N-1:0]          req_valid,
   input  logic [N-1:0][W-1:0]   req_data,
   output logic [N-1:0]          req_ack_r,
   input  logic                  l_busy_r,
   output logic                  l_in_pass_r,
   output logic [W-1:0]          l_in_r,
   output logic [$clog2(N)-1:0]  gnt_id_r,
   output logic                  idle_r,
   output logic                  to_err_r
);

   localparam int unsigned     IdxW    = idx_width(N);
   localparam int unsigned     CntW    = idx_width(BUSY_TO);
   localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TO - 1);
   localparam logic [IdxW-1:0] PtrRst  = IdxW'(N - 1);

   state_e          r_state;
   logic [CntW-1:0] r_cnt;

   logic [N-1:0]    w_gnt_oh;
   logic [IdxW-1:0] w_gnt_idx;
   logic            w_gnt_vld;
   logic            w_launch;

   // gnt_id_r doubles as the round-robin pointer, so it only moves on a grant.
   mcp_launch_arb_rr #(
      .N    (N),
      .IdxW (IdxW)
   ) u_rr (
      .i_req     (req_valid),
      .i_ptr     (gnt_id_r),
      .o_gnt_oh  (w_gnt_oh),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   // A stale busy from the previous transfer blocks any new grant.
   assign w_launch = w_gnt_vld & ~l_busy_r;

   // Arbiter FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge l_clk) begin
      if (!l_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         req_ack_r   <= '0;
         l_in_pass_r <= 1'b0;
         l_in_r      <= '0;
         gnt_id_r    <= PtrRst;
         idle_r      <= 1'b1;
         to_err_r    <= 1'b0;
      end else begin
         req_ack_r   <= '0;
         l_in_pass_r <= 1'b0;
         to_err_r    <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_launch) begin
                  r_state   <= StIssue;
                  l_in_r    <= req_data[w_gnt_idx];
                  gnt_id_r  <= w_gnt_idx;
                  req_ack_r <= w_gnt_oh;
                  idle_r    <= 1'b0;
               end
            end
            StIssue: begin
               // Payload has been stable for a cycle; now tell the MCP to take it.
               r_state     <= StWaitBusy;
               l_in_pass_r <= 1'b1;
               r_cnt       <= '0;
            end
            StWaitBusy: begin
               if (l_busy_r) begin
                  r_state <= StWaitDone;
               end else if (r_cnt == CntLast) begin
                  // MCP never acknowledged the pass; give up and flag it.
                  r_state  <= StIdle;
                  to_err_r <= 1'b1;
                  idle_r   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StWaitDone: begin
               if (!l_busy_r) begin
                  r_state <= StIdle;
                  idle_r  <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               idle_r  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/mcp_launch_arb.md
MCP_LAUNCH_ARB -- requirements
Module: mcp_launch_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter W, default 32, meaning the payload width, equal to the MCP launch-side data width.
REQ-003 SHALL have parameter BUSY_TO, default 8, meaning the maximum cycles from a pass pulse to the MCP raising busy.
REQ-004 SHALL have port l_clk, input, 1 bit: the single clock (launch domain).
REQ-005 SHALL have port l_rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid, input, N bits: per-requester request, held until acknowledged.
REQ-007 SHALL have port req_data, input, N x W bits: per-requester payload, stable while req_valid is high.
REQ-008 SHALL have port req_ack_r, output, N bits: one-cycle pulse consuming the granted request.
REQ-009 SHALL have port l_busy_r, input, 1 bit: busy flag from the MCP launch side.
REQ-010 SHALL have port l_in_pass_r, output, 1 bit: one-cycle pass pulse to the MCP.
REQ-011 SHALL have port l_in_r, output, W bits: payload to the MCP, held until the next issue.
REQ-012 SHALL have port gnt_id_r, output, clog2(N) bits: index of the last granted requester.
REQ-013 SHALL have port idle_r, output, 1 bit: high when the FSM is in IDLE.
REQ-014 SHALL have port to_err_r, output, 1 bit: one-cycle pulse on a busy timeout.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE: when any req_valid is high and l_busy_r is low, it SHALL select a winner round-robin, starting at (last gnt_id_r + 1) mod N, and go to ISSUE on the next edge.
REQ-017 The IDLE->ISSUE edge SHALL register req_data[winner] into l_in_r, set gnt_id_r to winner, and pulse req_ack_r[winner].
REQ-018 ISSUE SHALL assert l_in_pass_r for exactly one cycle, then go to WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on l_busy_r high, and SHALL restart its cycle counter on entry.
REQ-020 If l_busy_r stays low for BUSY_TO cycles in WAIT_BUSY, the block SHALL pulse to_err_r for one cycle and return to IDLE.
REQ-021 WAIT_DONE SHALL return to IDLE on the first cycle l_busy_r is low.
REQ-022 Latency SHALL be: req_valid high in IDLE -> req_ack_r at +1 cycle -> l_in_pass_r at +2 cycles.
REQ-023 With l_busy_r high in IDLE (stale busy), the block SHALL NOT grant, and SHALL wait.
REQ-024 At most one req_ack_r bit and one l_in_pass_r pulse SHALL be active per transaction; no back-to-back pass without an intervening busy-low in IDLE.
REQ-025 If a requester drops req_valid before ack, the block SHALL NOT grant it; a request dropped after arbitration SHALL still be issued.
REQ-026 Simultaneous requests SHALL be served in rotating order; no requester waits more than N transactions.
REQ-027 gnt_id_r wrap-around SHALL continue rotation at 0 after N-1.
REQ-028 The round-robin pointer SHALL advance only on a grant, not on a timeout.

Reset
REQ-029 While l_rst is low at an l_clk edge, the block SHALL set state=IDLE, l_in_pass_r=0, req_ack_r=0, l_in_r=0, gnt_id_r=N-1 (so requester 0 wins first), idle_r=1, to_err_r=0, and the counter to 0.
REQ-030 Reset mid-transaction SHALL abort immediately, with no pass pulse in the cycle after reset deassertion.

Structure
REQ-031 A shared package mcp_launch_arb_pkg SHALL hold the FSM state enum and the default constants N, W and BUSY_TO.
REQ-032 Round-robin selection SHALL be a sub-module mcp_launch_arb_rr (request vector plus pointer in, one-hot grant plus index out, combinational).
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 The bench SHALL cover: single req_valid[2]=1, data 0xA5A5_0002, busy rises at +1 and falls at +4 -> ack[2] at cycle 1, pass at cycle 2, l_in_r=0xA5A5_0002, idle_r at cycle 7.
REQ-035 The bench SHALL cover: all four requesting continuously after reset -> grant order 0,1,2,3,0; exactly one pass per busy cycle.
REQ-036 The bench SHALL cover: l_busy_r held high from reset release for 10 cycles with req_valid[1]=1 -> no ack until busy falls, then ack[1] the next cycle.
REQ-037 The bench SHALL cover: l_busy_r never rises after pass -> to_err_r pulse BUSY_TO=8 cycles after entering WAIT_BUSY, return to IDLE, pointer unchanged.
REQ-038 The bench SHALL cover: l_rst low during WAIT_DONE -> all outputs at reset values the next cycle; after release, requester 0 is granted first.
REQ-039 The bench SHALL cover: req_valid[3] pulsed for one cycle while in WAIT_DONE -> never acknowledged.
